// File: rtl/dmi_jtag_ctrl_pkg.sv
// rtl/dmi_jtag_ctrl_pkg.sv - DMI operation and error encodings shared by the DTM logic
package dm;

   typedef enum logic [1:0] {
      DTM_NOP   = 2'd0,
      DTM_READ  = 2'd1,
      DTM_WRITE = 2'd2
   } dtm_op_e;

   typedef enum logic [1:0] {
      DMI_NO_ERROR  = 2'd0,
      DMI_RESERVED  = 2'd1,
      DMI_OP_FAILED = 2'd2,
      DMI_BUSY      = 2'd3
   } dmi_error_e;

endpackage

// File: rtl/dmi_jtag_ctrl.sv
// rtl/dmi_jtag_ctrl.sv - DTM engine: owns the DMI data register and drives DMI requests
module dmi_jtag_ctrl
   import dm::*;
#(
   parameter int unsigned AddrWidth     = 7,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 test_logic_rst_i,
   input  logic                 capture_dr_i,
   input  logic                 shift_dr_i,
   input  logic                 update_dr_i,
   input  logic                 dmi_access_i,
   input  logic                 dtmcs_select_i,
   input  logic                 dmi_reset_i,
   input  logic                 dmi_hardreset_i,
   input  logic                 tdi_i,
   output logic                 tdo_o,
   output logic                 req_valid_o,
   input  logic                 req_ready_i,
   output logic [AddrWidth-1:0] req_addr_o,
   output logic [DataWidth-1:0] req_data_o,
   output logic [1:0]           req_op_o,
   input  logic                 resp_valid_i,
   output logic                 resp_ready_o,
   input  logic [DataWidth-1:0] resp_data_i,
   input  logic [1:0]           resp_resp_i,
   output logic [1:0]           error_o,
   output logic                 busy_o,
   output logic [2:0]           state_o
);

   localparam int unsigned DrWidth    = AddrWidth + DataWidth + 2;
   localparam int unsigned TimerWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [TimerWidth-1:0] TimerLast =
      TimerWidth'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

   typedef enum logic [2:0] {
      IDLE             = 3'd0,
      READ             = 3'd1,
      WAIT_READ_VALID  = 3'd2,
      WRITE            = 3'd3,
      WAIT_WRITE_VALID = 3'd4
   } state_e;

   state_e                 r_state;
   logic [DrWidth-1:0]     r_dr;
   logic [AddrWidth-1:0]   r_addr;
   logic [DataWidth-1:0]   r_data;
   dmi_error_e             r_error;
   logic [TimerWidth-1:0]  r_timer;

   logic       w_reset, w_capture, w_shift, w_update, w_clear;
   logic       w_in_wait, w_resp, w_timeout;
   logic       w_busy_evt, w_fail_evt, w_busy_resp;
   dmi_error_e w_capture_st;
   dtm_op_e    w_dr_op;

   assign w_reset   = rst_i | test_logic_rst_i;
   assign w_capture = capture_dr_i & dmi_access_i;
   assign w_shift   = shift_dr_i & dmi_access_i;
   assign w_update  = update_dr_i & dmi_access_i;
   assign w_clear   = dmi_reset_i & dtmcs_select_i;

   assign w_in_wait = (r_state == WAIT_READ_VALID) || (r_state == WAIT_WRITE_VALID);
   assign w_resp    = w_in_wait & resp_valid_i;
   assign w_timeout = (TimeoutCycles != 0) && w_in_wait && !resp_valid_i && (r_timer == TimerLast);

   // A capture during a pending read would expose stale data, so it is reported as busy.
   assign w_busy_evt  = (update_dr_i && (r_state != IDLE)) ||
                        (w_capture && ((r_state == READ) || (r_state == WAIT_READ_VALID)));
   assign w_fail_evt  = (w_resp && (resp_resp_i == 2'd2)) || w_timeout;
   assign w_busy_resp = w_resp && (resp_resp_i == 2'd3);

   assign w_capture_st = w_busy_evt ? DMI_BUSY : r_error;
   assign w_dr_op      = dtm_op_e'(r_dr[1:0]);

   always_ff @(posedge clk_i) begin
      if (w_reset) begin
         r_state <= IDLE;
         r_dr    <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_error <= DMI_NO_ERROR;
         r_timer <= '0;
      end else begin
         if (w_capture) begin
            r_dr <= {r_addr, r_data, w_capture_st};
         end else if (w_shift) begin
            r_dr <= {tdi_i, r_dr[DrWidth-1:1]};
         end

         // Hardreset aborts any transaction but leaves the DR and payload untouched.
         if (dmi_hardreset_i) begin
            r_state <= IDLE;
            r_error <= DMI_NO_ERROR;
            r_timer <= '0;
         end else begin
            if (w_clear) begin
               r_error <= DMI_NO_ERROR;
            end else if (r_error == DMI_NO_ERROR) begin
               if (w_fail_evt) begin
                  r_error <= DMI_OP_FAILED;
               end else if (w_busy_evt || w_busy_resp) begin
                  r_error <= DMI_BUSY;
               end
            end

            r_timer <= w_in_wait ? r_timer + TimerWidth'(1) : '0;

            unique case (r_state)
               IDLE: begin
                  if (w_update && (r_error == DMI_NO_ERROR)) begin
                     r_addr <= r_dr[DrWidth-1 -: AddrWidth];
                     r_data <= r_dr[DataWidth+1:2];
                     if (w_dr_op == DTM_READ) begin
                        r_state <= READ;
                     end else if (w_dr_op == DTM_WRITE) begin
                        r_state <= WRITE;
                     end
                  end
               end
               READ: begin
                  if (req_ready_i) r_state <= WAIT_READ_VALID;
               end
               WRITE: begin
                  if (req_ready_i) r_state <= WAIT_WRITE_VALID;
               end
               WAIT_READ_VALID: begin
                  if (resp_valid_i) begin
                     if (resp_resp_i == 2'd0) r_data <= resp_data_i;
                     r_state <= IDLE;
                  end else if (w_timeout) begin
                     r_state <= IDLE;
                  end
               end
               WAIT_WRITE_VALID: begin
                  if (resp_valid_i || w_timeout) r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign tdo_o        = r_dr[0];
   assign req_valid_o  = (r_state == READ) || (r_state == WRITE);
   assign req_addr_o   = r_addr;
   assign req_data_o   = r_data;
   assign req_op_o     = (r_state == READ)  ? DTM_READ  :
                         (r_state == WRITE) ? DTM_WRITE : DTM_NOP;
   assign resp_ready_o = 1'b1;
   assign error_o      = r_error;
   assign busy_o       = (r_state != IDLE);
   assign state_o      = r_state;

endmodule

// File: tb/tb_dmi_jtag_ctrl.sv
// tb/tb_dmi_jtag_ctrl.sv - self-checking bench for dmi_jtag_ctrl
module tb_dmi_jtag_ctrl;

   localparam int AW  = 7;
   localparam int DW  = 32;
   localparam int DRW = AW + DW + 2;

   logic          clk, rst, test_logic_rst;
   logic          capture_dr, shift_dr, update_dr;
   logic          dmi_access, dtmcs_select, dmi_reset, dmi_hardreset;
   logic          tdi, tdo;
   logic          req_valid, req_ready;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data;
   logic [1:0]    req_op;
   logic          resp_valid, resp_ready;
   logic [DW-1:0] resp_data;
   logic [1:0]    resp_resp;
   logic [1:0]    error;
   logic          busy;
   logic [2:0]    state;

   int checks = 0;
   int errors = 0;

   dmi_jtag_ctrl #(
      .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(8)
   ) dut (
      .clk_i(clk), .rst_i(rst), .test_logic_rst_i(test_logic_rst),
      .capture_dr_i(capture_dr), .shift_dr_i(shift_dr), .update_dr_i(update_dr),
      .dmi_access_i(dmi_access), .dtmcs_select_i(dtmcs_select),
      .dmi_reset_i(dmi_reset), .dmi_hardreset_i(dmi_hardreset),
      .tdi_i(tdi), .tdo_o(tdo),
      .req_valid_o(req_valid), .req_ready_i(req_ready),
      .req_addr_o(req_addr), .req_data_o(req_data), .req_op_o(req_op),
      .resp_valid_i(resp_valid), .resp_ready_o(resp_ready),
      .resp_data_i(resp_data), .resp_resp_i(resp_resp),
      .error_o(error), .busy_o(busy), .state_o(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [1:0]    op;
      logic [DW-1:0] rdata;
      logic [1:0]    rresp;
      logic          exp_req;
      logic [1:0]    exp_err;
      logic [DW-1:0] exp_data;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic capture_shift(input logic [DRW-1:0] din, output logic [DRW-1:0] dout);
      capture_dr = 1'b1;
      step();
      capture_dr = 1'b0;
      shift_dr   = 1'b1;
      for (int i = 0; i < DRW; i++) begin
         tdi     = din[i];
         dout[i] = tdo;
         step();
      end
      shift_dr = 1'b0;
      tdi      = 1'b0;
   endtask

   task automatic update();
      update_dr = 1'b1;
      step();
      update_dr = 1'b0;
   endtask

   task automatic clear_err();
      dtmcs_select = 1'b1;
      dmi_reset    = 1'b1;
      step();
      dtmcs_select = 1'b0;
      dmi_reset    = 1'b0;
   endtask

   task automatic handshake();
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
   endtask

   logic [DRW-1:0] dout;

   initial begin
      //             addr    data          op    rdata         rresp req  err    exp_data
      vecs[0] = '{7'h11, 32'h00000000, 2'd1, 32'hDEADBEEF, 2'd0, 1'b1, 2'd0, 32'hDEADBEEF};
      vecs[1] = '{7'h10, 32'h00000001, 2'd2, 32'hCAFEF00D, 2'd0, 1'b1, 2'd0, 32'h00000001};
      vecs[2] = '{7'h22, 32'h12345678, 2'd1, 32'hAAAAAAAA, 2'd2, 1'b1, 2'd2, 32'h12345678};
      vecs[3] = '{7'h05, 32'hA5A5A5A5, 2'd2, 32'h11111111, 2'd3, 1'b1, 2'd3, 32'hA5A5A5A5};
      vecs[4] = '{7'h7F, 32'hFFFFFFFF, 2'd0, 32'h0,        2'd0, 1'b0, 2'd0, 32'hFFFFFFFF};
      vecs[5] = '{7'h01, 32'h0F0F0F0F, 2'd3, 32'h0,        2'd0, 1'b0, 2'd0, 32'h0F0F0F0F};
      vecs[6] = '{7'h40, 32'h00000000, 2'd1, 32'h80000001, 2'd0, 1'b1, 2'd0, 32'h80000001};
      vecs[7] = '{7'h3C, 32'h0000BEEF, 2'd2, 32'h0,        2'd2, 1'b1, 2'd2, 32'h0000BEEF};

      rst = 1'b1; test_logic_rst = 1'b0;
      capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
      dmi_access = 1'b1; dtmcs_select = 1'b0; dmi_reset = 1'b0; dmi_hardreset = 1'b0;
      tdi = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; resp_resp = 2'd0;
      step();
      step();
      rst = 1'b0;

      chk("rst_req_valid", req_valid, 0);
      chk("rst_resp_ready", resp_ready, 1);
      chk("rst_error", error, 0);
      chk("rst_busy", busy, 0);
      chk("rst_state", state, 0);
      chk("rst_tdo", tdo, 0);
      chk("rst_addr", req_addr, 0);
      chk("rst_data", req_data, 0);
      chk("rst_op", req_op, 0);

      for (int v = 0; v < 8; v++) begin
         capture_shift({vecs[v].addr, vecs[v].data, vecs[v].op}, dout);
         update();
         chk($sformatf("v%0d_req_valid", v), req_valid, vecs[v].exp_req);
         if (vecs[v].exp_req) begin
            chk($sformatf("v%0d_req_op", v), req_op, vecs[v].op);
            chk($sformatf("v%0d_req_addr", v), req_addr, vecs[v].addr);
            chk($sformatf("v%0d_req_data", v), req_data, vecs[v].data);
            handshake();
            chk($sformatf("v%0d_busy_wait", v), busy, 1);
            step();
            chk($sformatf("v%0d_busy_wait2", v), busy, 1);
            resp_valid = 1'b1;
            resp_data  = vecs[v].rdata;
            resp_resp  = vecs[v].rresp;
            step();
            resp_valid = 1'b0;
            resp_resp  = 2'd0;
         end
         chk($sformatf("v%0d_busy_done", v), busy, 0);
         chk($sformatf("v%0d_error", v), error, vecs[v].exp_err);
         capture_shift('0, dout);
         chk($sformatf("v%0d_dr_out", v), dout, {vecs[v].addr, vecs[v].exp_data, vecs[v].exp_err});
         clear_err();
         chk($sformatf("v%0d_cleared", v), error, 0);
      end

      // Busy: update during an outstanding read, then a blocked update.
      capture_shift({7'h11, 32'h0, 2'd1}, dout);
      update();
      handshake();
      update();
      chk("busy_err", error, 3);
      resp_valid = 1'b1; resp_data = 32'h00000055; resp_resp = 2'd0;
      step();
      resp_valid = 1'b0;
      chk("busy_idle", state, 0);
      chk("busy_rdata", req_data, 32'h55);
      capture_shift({7'h10, 32'h1, 2'd2}, dout);
      chk("busy_dr_out", dout, {7'h11, 32'h55, 2'd3});
      update();
      chk("busy_ignored_valid", req_valid, 0);
      chk("busy_ignored_addr", req_addr, 7'h11);
      clear_err();
      chk("busy_cleared", error, 0);

      // Timeout after 8 cycles in WaitReadValid, late response ignored.
      capture_shift({7'h33, 32'h0, 2'd1}, dout);
      update();
      handshake();
      for (int i = 0; i < 7; i++) step();
      chk("to_still_busy", busy, 1);
      step();
      chk("to_idle", busy, 0);
      chk("to_error", error, 2);
      resp_valid = 1'b1; resp_data = 32'h00000BAD; resp_resp = 2'd0;
      step();
      resp_valid = 1'b0;
      chk("to_late_state", state, 0);
      chk("to_late_error", error, 2);
      chk("to_late_data", req_data, 0);
      clear_err();

      // Hardreset while Read is stalled, with a busy error pending.
      capture_shift({7'h2A, 32'hC0FFEE00, 2'd1}, dout);
      update();
      chk("hr_req_valid", req_valid, 1);
      update();
      chk("hr_err_set", error, 3);
      dmi_hardreset = 1'b1;
      step();
      dmi_hardreset = 1'b0;
      chk("hr_req_dropped", req_valid, 0);
      chk("hr_state", state, 0);
      chk("hr_error", error, 0);
      chk("hr_addr_kept", req_addr, 7'h2A);
      chk("hr_data_kept", req_data, 32'hC0FFEE00);

      // Clear wins over a same-cycle failed response.
      capture_shift({7'h07, 32'h0, 2'd1}, dout);
      update();
      handshake();
      resp_valid = 1'b1; resp_resp = 2'd2; dtmcs_select = 1'b1; dmi_reset = 1'b1;
      step();
      resp_valid = 1'b0; resp_resp = 2'd0; dtmcs_select = 1'b0; dmi_reset = 1'b0;
      chk("clr_beats_set", error, 0);
      chk("clr_idle", state, 0);

      test_logic_rst = 1'b1;
      step();
      test_logic_rst = 1'b0;
      chk("tlr_addr", req_addr, 0);
      chk("tlr_data", req_data, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
